slave_bus_port: RTL and testbench
=================================

# slave_bus_port

Slave-side endpoint of the serial master–slave bus: directly downstream of the external master, consuming its serial `control`, `wD` and `valid` lines and driving `rD` and `ready` back. It decodes the 19-bit control frame, filters on its own slave ID, and converts serial write/read traffic into single-port memory accesses. It supports single-word and burst transfers, and sits between the bus wiring and a slave's local BRAM.

## Interface
- `DATA_WIDTH`, 8, bits per data word on the bus and the memory
- `ADDR_WIDTH`, 12, memory address width
- `ID_WIDTH`, 2, slave ID field width
- `MY_ID`, 0, this slave's ID
- `clk`  in  1  system clock; one clock only
- `rst`  in  1  reset; reset is synchronous and active-high
- `control`  in  1  serial control frame and stop pulse from the master; idles low
- `wD`  in  1  serial write data, MSB first
- `valid`  in  1  high when `wD` carries a data bit this cycle
- `rD`  out  1  serial read data, MSB first
- `ready`  out  1  high when the port is idle or accepting write bits
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_we`  out  1  one-cycle write strobe
- `mem_re`  out  1  one-cycle read strobe; `mem_rdata` is valid on the cycle after
- `mem_rdata`  in  DATA_WIDTH  memory read data

## Operation
- Frame, MSB first on `control`: `111` start, then ID (ID_WIDTH), R/W (1 = write), burst (1 = burst), then start address (ADDR_WIDTH). FRAME_LEN = 19 with the defaults.
- IDLE: shift `control` each cycle. Three consecutive 1s move the port to HDR. The header bit counter starts at 0.
- HDR: capture ID_WIDTH+2+ADDR_WIDTH bits. Cycle T is the cycle the last header bit is sampled.
  - If the ID does not match `MY_ID`: go to IDLE at T+1. No memory activity occurs.
  - If the ID matches: go to WR_DATA or RD_FETCH.
- WR_DATA: each cycle with `valid`=1 shifts `wD` into the shift register and increments the bit count.
  - `valid`=0 holds the partial word.
  - On the DATA_WIDTH-th bit, the next cycle has `mem_we`=1, `mem_wdata`=word and `mem_addr`=current address. The address then increments. Bits of the next word may arrive in that same cycle.
  - Non-burst: go to IDLE after the single word's `mem_we`.
  - Burst: continue until a stop. A stop is `control`=1 with `valid`=0.
    - Stop at a word boundary: go to IDLE.
    - Stop mid-word: discard the partial word, no `mem_we`, go to IDLE.
- RD_FETCH (1 cycle): `mem_re`=1, `mem_addr`=address.
- RD_WAIT (1 cycle): load `mem_rdata` into the shift register.
- RD_SHIFT (DATA_WIDTH cycles): drive `rD` MSB first, one bit per cycle. Then increment the address.
  - Non-burst: go to IDLE.
  - Burst: return to RD_FETCH unless a stop was latched. `control`=1 anywhere in RD_* latches the stop, and the current word always completes.
- Address arithmetic is modulo 2^ADDR_WIDTH: the address after 0xFFF is 0x000.
- `ready`: 1 in IDLE and WR_DATA, 0 in HDR, RD_FETCH, RD_WAIT and RD_SHIFT.
- `rD`: 0 outside RD_SHIFT.
- Reset in any state: go to IDLE, discard partial words, clear the latched stop, and issue no strobe on the following cycle.

## Timing
- Reset values: `rD`=0, `ready`=1, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0. All outputs are registered.
- Write latency: the last bit of a word is sampled at cycle W; `mem_we` is high at W+1 for exactly one cycle.
- Read: `mem_re` at T+1, data load at T+2, `rD` bit k (MSB = 0) at T+3+k, and `ready` returns high at T+3+DATA_WIDTH for non-burst.
- Burst read gap: 2 cycles (FETCH, WAIT) between words, so each word occupies DATA_WIDTH+2 cycles.
- Start bits arriving while the port is not in IDLE are ignored.
- `valid` and a stop in the same cycle: the stop wins and the bit is discarded.

## Structure
- Package `slave_bus_pkg` holds:
  - state enum `{IDLE, HDR, WR_DATA, RD_FETCH, RD_WAIT, RD_SHIFT}`
  - `START_PATTERN`=3'b111
  - R/W and burst encodings
  - FRAME_LEN derivation
- Sub-module `serial_shifter`: a DATA_WIDTH shift register with parallel load, serial in/out, bit counter and a word-done flag. It is instantiated once and shared between write and read, since they never overlap.

## Test plan
- MY_ID=01; frame write, non-burst, addr 0x003, then bits of 0xA5 with `valid`=1 → `mem_we` one cycle with addr 0x003 and data 0xA5; `ready`=1; back in IDLE.
- Burst write at addr 0xFFE of 0x11, 0x22, 0x33, then stop → writes at 0xFFE, 0xFFF and 0x000 (wrap), then IDLE.
- Burst write with `valid` low for 3 cycles mid-word, then stop after 4 bits of the second word → first word written intact, second word discarded, exactly one `mem_we`.
- Read, non-burst, addr 0x005, memory holds 0x5C → `mem_re` at T+1, `rD` = 0,1,0,1,1,1,0,0 on T+3..T+10, `ready` high at T+11.
- Frame with ID 10 → no `mem_re` or `mem_we`, `ready` high from T+1, and a following valid frame is decoded normally.
- `rst` asserted at the 5th bit of a burst read → next cycle `rD`=0, `ready`=1, no strobes, and a new frame after reset works.

Source files
------------

// File: rtl/slave_bus_pkg.sv
// Shared types and constants for the serial bus slave port.
package slave_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    WR_DATA  = 3'd2,
    RD_FETCH = 3'd3,
    RD_WAIT  = 3'd4,
    RD_SHIFT = 3'd5
  } state_t;

  localparam logic [2:0] START_PATTERN = 3'b111;
  localparam logic       RW_WRITE      = 1'b1;
  localparam logic       XFER_BURST    = 1'b1;

  // Full control frame: start pattern, ID, R/W, burst, start address.
  function automatic int frame_len(input int id_w, input int addr_w);
    return $bits(START_PATTERN) + id_w + 2 + addr_w;
  endfunction

endpackage

// File: rtl/slave_bus_port_shifter.sv
// Word shift register shared by the write (serial in) and read (serial out)
// paths; the two never overlap so one register serves both.
module serial_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  shift_i,
  input  logic                  sin_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  at_last_bit_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // at_last_bit_o: the next shift completes a word (word-done when shift_i is high).
  assign data_o        = data_q;
  assign at_last_bit_o = (cnt_q == CW'(DATA_WIDTH - 1));

  // Next-state: clear beats load beats shift; count wraps at a full word.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = {data_q[DATA_WIDTH-2:0], sin_i};
      cnt_d  = at_last_bit_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_bus_port.sv
// Slave endpoint of the serial master-slave bus: decodes the control frame,
// filters on MY_ID and turns serial write/read traffic into memory strobes.
// Handshake: ready is high while the port can take write bits (IDLE, WR_DATA);
// a wD bit is consumed on each cycle valid is high in WR_DATA, and control=1
// during a burst is a stop that overrides valid.
module slave_bus_port
  import slave_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 2,
  parameter int MY_ID      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  control,
  input  logic                  wD,
  input  logic                  valid,
  output logic                  rD,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output state_t                dbg_state_o
);

  localparam int FRAME_LEN = frame_len(ID_WIDTH, ADDR_WIDTH);
  localparam int HDR_LEN   = FRAME_LEN - $bits(START_PATTERN);
  localparam int HCW       = $clog2(HDR_LEN);

  state_t                state_q, state_d;
  logic [2:0]            start_q, start_d;
  logic [HDR_LEN-2:0]    hdr_q, hdr_d;
  logic [HDR_LEN-1:0]    hdr_full;
  logic [HCW-1:0]        hcnt_q, hcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  burst_q, burst_d;
  logic                  stop_q, stop_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic                  rd_q, rd_d, ready_q;
  logic                  sh_load, sh_shift, sh_sin, sh_last;
  logic [DATA_WIDTH-1:0] sh_data, sh_load_data;

  assign rD          = rd_q;
  assign ready       = ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign dbg_state_o = state_q;

  // The shifter holds the bits still to be sent on a read, so the first bit
  // goes straight from mem_rdata to rD and the rest are loaded pre-shifted.
  assign sh_load_data = {mem_rdata[DATA_WIDTH-2:0], 1'b0};

  serial_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (state_q == IDLE),
    .load_i        (sh_load),
    .load_data_i   (sh_load_data),
    .shift_i       (sh_shift),
    .sin_i         (sh_sin),
    .data_o        (sh_data),
    .at_last_bit_o (sh_last)
  );

  // Next-state and registered-output values for the frame/transfer FSM.
  always_comb begin
    state_d     = state_q;
    start_d     = '0;
    hdr_d       = hdr_q;
    hcnt_d      = hcnt_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    stop_d      = stop_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_d        = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_sin      = 1'b0;
    hdr_full    = {hdr_q, control};
    case (state_q)
      IDLE: begin
        start_d = {start_q[1:0], control};
        stop_d  = 1'b0;
        hcnt_d  = '0;
        if (start_d == START_PATTERN) begin
          state_d = HDR;
          start_d = '0;
        end
      end
      HDR: begin
        hdr_d  = hdr_full[HDR_LEN-2:0];
        hcnt_d = hcnt_q + HCW'(1);
        if (hcnt_q == HCW'(HDR_LEN - 1)) begin
          hcnt_d = '0;
          if (hdr_full[HDR_LEN-1 -: ID_WIDTH] != ID_WIDTH'(MY_ID)) begin
            state_d = IDLE;
          end else begin
            addr_d  = hdr_full[ADDR_WIDTH-1:0];
            burst_d = hdr_full[ADDR_WIDTH];
            if (hdr_full[ADDR_WIDTH+1] == RW_WRITE) begin
              state_d = WR_DATA;
            end else begin
              state_d    = RD_FETCH;
              mem_re_d   = 1'b1;
              mem_addr_d = hdr_full[ADDR_WIDTH-1:0];
            end
          end
        end
      end
      WR_DATA: begin
        if ((burst_q == XFER_BURST) && control) begin
          // Stop: any partial word is dropped when IDLE clears the shifter.
          state_d = IDLE;
        end else if (valid) begin
          sh_shift = 1'b1;
          sh_sin   = wD;
          if (sh_last) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {sh_data[DATA_WIDTH-2:0], wD};
            mem_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            if (burst_q != XFER_BURST) state_d = IDLE;
          end
        end
      end
      RD_FETCH: begin
        stop_d  = stop_q | control;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stop_d  = stop_q | control;
        sh_load = 1'b1;
        rd_d    = mem_rdata[DATA_WIDTH-1];
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        stop_d   = stop_q | control;
        sh_shift = 1'b1;
        if (sh_last) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if ((burst_q == XFER_BURST) && !stop_d) begin
            state_d    = RD_FETCH;
            mem_re_d   = 1'b1;
            mem_addr_d = addr_d;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_d = sh_data[DATA_WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= '0;
      hdr_q       <= '0;
      hcnt_q      <= '0;
      addr_q      <= '0;
      burst_q     <= 1'b0;
      stop_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_q        <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      hdr_q       <= hdr_d;
      hcnt_q      <= hcnt_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      stop_q      <= stop_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_q        <= rd_d;
      ready_q     <= (state_d == IDLE) || (state_d == WR_DATA);
    end
  end

endmodule

// File: tb/tb_slave_bus_port.sv
// Directed bench for slave_bus_port (MY_ID = 1) with a small BRAM model.
module tb_slave_bus_port;
  import slave_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        control = 1'b0;
  logic        wD = 1'b0;
  logic        valid = 1'b0;
  logic        rD, ready, mem_we, mem_re;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  state_t      dbg_state;

  logic [7:0]  mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          base_we, base_re;
  logic [7:0]  w96;

  slave_bus_port #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .ID_WIDTH(2), .MY_ID(1)
  ) dut (
    .clk(clk), .rst(rst), .control(control), .wD(wD), .valid(valid),
    .rD(rD), .ready(ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory model: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    if (mem_re === 1'b1) re_cnt <= re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; afterwards outputs show the next cycle.
  task automatic tick(input logic c, input logic v, input logic d);
    control = c;
    valid   = v;
    wD      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] id, input logic rw, input logic burst,
                            input logic [11:0] addr);
    logic [18:0] f;
    f = {3'b111, id, rw, burst, addr};
    for (int i = 18; i >= 0; i--) tick(f[i], 1'b0, 1'b0);
  endtask

  task automatic write_word(input logic [7:0] w, input logic [11:0] a, input string tag);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b1, w[7-k]);
      if (k < 7) chk({tag, "_we_low"}, 32'(mem_we), 32'd0);
    end
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_wdata), 32'(w));
  endtask

  task automatic read_bits(input logic [7:0] exp, input int stop_at, input string tag);
    for (int k = 0; k < 8; k++) begin
      tick(k == stop_at, 1'b0, 1'b0);
      chk({tag, "_rd"}, 32'(rD), 32'(exp[7-k]));
      chk({tag, "_ready_low"}, 32'(ready), 32'd0);
    end
  endtask

  initial begin
    mem[12'h005] = 8'h5C;
    mem[12'h006] = 8'hE1;
    mem[12'h200] = 8'hC3;
    mem[12'h201] = 8'h96;

    // Reset values.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_rd", 32'(rD), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // Single write of 0xA5 to 0x003.
    send_frame(2'b01, 1'b1, 1'b0, 12'h003);
    chk("w1_state", 32'(dbg_state), 32'(WR_DATA));
    chk("w1_ready", 32'(ready), 32'd1);
    write_word(8'hA5, 12'h003, "w1");
    chk("w1_idle", 32'(dbg_state), 32'(IDLE));
    chk("w1_ready_after", 32'(ready), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("w1_we_one_cycle", 32'(mem_we), 32'd0);

    // Burst write with address wrap, then stop.
    send_frame(2'b01, 1'b1, 1'b1, 12'hFFE);
    write_word(8'h11, 12'hFFE, "bw0");
    write_word(8'h22, 12'hFFF, "bw1");
    write_word(8'h33, 12'h000, "bw2");
    tick(1'b1, 1'b0, 1'b0);
    chk("bw_stop_state", 32'(dbg_state), 32'(IDLE));
    chk("bw_stop_we", 32'(mem_we), 32'd0);
    tick(1'b0, 1'b0, 1'b0);

    // Burst write with a 3-cycle valid gap, then a mid-word stop.
    base_we = we_cnt;
    send_frame(2'b01, 1'b1, 1'b1, 12'h100);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, k[1]);   // 0,0,1,1 = upper nibble 0x3
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      chk("gap_state", 32'(dbg_state), 32'(WR_DATA));
      chk("gap_we", 32'(mem_we), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("gap_we", 32'(mem_we), 32'd1);
    chk("gap_addr", 32'(mem_addr), 32'h100);
    chk("gap_data", 32'(mem_wdata), 32'h3C);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("mid_stop_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_stop_we", 32'(mem_we), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("mid_stop_we_count", 32'(we_cnt - base_we), 32'd1);

    // Single read of 0x5C at 0x005.
    send_frame(2'b01, 1'b0, 1'b0, 12'h005);
    chk("r1_re", 32'(mem_re), 32'd1);
    chk("r1_addr", 32'(mem_addr), 32'h005);
    chk("r1_ready", 32'(ready), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("r1_re_one_cycle", 32'(mem_re), 32'd0);
    chk("r1_rd_wait", 32'(rD), 32'd0);
    read_bits(8'h5C, -1, "r1");
    tick(1'b0, 1'b0, 1'b0);
    chk("r1_ready_back", 32'(ready), 32'd1);
    chk("r1_rd_zero", 32'(rD), 32'd0);
    chk("r1_idle", 32'(dbg_state), 32'(IDLE));

    // Foreign ID is ignored, next frame decodes normally.
    base_we = we_cnt;
    base_re = re_cnt;
    send_frame(2'b10, 1'b1, 1'b0, 12'h007);
    chk("id_ready", 32'(ready), 32'd1);
    chk("id_state", 32'(dbg_state), 32'(IDLE));
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b1);
    chk("id_no_we", 32'(we_cnt - base_we), 32'd0);
    chk("id_no_re", 32'(re_cnt - base_re), 32'd0);
    send_frame(2'b01, 1'b0, 1'b0, 12'h005);
    chk("id_next_re", 32'(mem_re), 32'd1);
    chk("id_next_addr", 32'(mem_addr), 32'h005);
    tick(1'b0, 1'b0, 1'b0);
    read_bits(8'h5C, -1, "id_next");
    tick(1'b0, 1'b0, 1'b0);

    // Burst read with a stop latched mid-word: word completes, then IDLE.
    send_frame(2'b01, 1'b0, 1'b1, 12'h006);
    tick(1'b0, 1'b0, 1'b0);
    read_bits(8'hE1, 2, "stop_rd");
    tick(1'b0, 1'b0, 1'b0);
    chk("stop_rd_state", 32'(dbg_state), 32'(IDLE));
    chk("stop_rd_re", 32'(mem_re), 32'd0);
    chk("stop_rd_ready", 32'(ready), 32'd1);

    // Burst read, second word interrupted by reset at its 5th bit.
    send_frame(2'b01, 1'b0, 1'b1, 12'h200);
    chk("br_re0_addr", 32'(mem_addr), 32'h200);
    tick(1'b0, 1'b0, 1'b0);
    read_bits(8'hC3, -1, "br0");
    tick(1'b0, 1'b0, 1'b0);
    chk("br_re1", 32'(mem_re), 32'd1);
    chk("br_re1_addr", 32'(mem_addr), 32'h201);
    tick(1'b0, 1'b0, 1'b0);
    w96 = 8'h96;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("br1_rd", 32'(rD), 32'(w96[7-k]));
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("brst_rd", 32'(rD), 32'd0);
    chk("brst_ready", 32'(ready), 32'd1);
    chk("brst_re", 32'(mem_re), 32'd0);
    chk("brst_we", 32'(mem_we), 32'd0);
    chk("brst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    send_frame(2'b01, 1'b1, 1'b0, 12'h010);
    write_word(8'h7E, 12'h010, "post_rst");
    chk("post_rst_idle", 32'(dbg_state), 32'(IDLE));
    tick(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
